// File: rtl/player_hit_detector_if.sv
// Player hit detector bus: frame tick, level enable, object coordinates
// and the hit/retire/immunity outputs.
interface player_hit_detector_if;
  logic       frame_clk;
  logic       enable;
  logic [9:0] Char_X, Char_Y;
  logic [9:0] Monster_X, Monster_Y, Monster_X_2, Monster_Y_2;
  logic [9:0] monster_bullet_X_L, monster_bullet_Y_L;
  logic [9:0] monster_bullet_X_R, monster_bullet_Y_R;
  logic [9:0] monster_bullet_X_U, monster_bullet_Y_U;
  logic [9:0] monster_bullet_X_D, monster_bullet_Y_D;
  logic       hited;
  logic [3:0] bullet_clear;
  logic       invuln;

  // Level side: drives the tick, enable and coordinates, consumes results.
  modport master (
    output frame_clk, enable, Char_X, Char_Y,
           Monster_X, Monster_Y, Monster_X_2, Monster_Y_2,
           monster_bullet_X_L, monster_bullet_Y_L, monster_bullet_X_R, monster_bullet_Y_R,
           monster_bullet_X_U, monster_bullet_Y_U, monster_bullet_X_D, monster_bullet_Y_D,
    input  hited, bullet_clear, invuln
  );

  // Detector side.
  modport slave (
    input  frame_clk, enable, Char_X, Char_Y,
           Monster_X, Monster_Y, Monster_X_2, Monster_Y_2,
           monster_bullet_X_L, monster_bullet_Y_L, monster_bullet_X_R, monster_bullet_Y_R,
           monster_bullet_X_U, monster_bullet_Y_U, monster_bullet_X_D, monster_bullet_Y_D,
    output hited, bullet_clear, invuln
  );
endinterface

// File: rtl/player_hit_detector.sv
// Per-level player hit detector. Once per frame it snapshots the player,
// two monsters and four monster bullets, tests box overlap, emits a single
// hit pulse plus a bullet-retire mask, then stays immune for INVULN_FRAMES.
module player_hit_detector #(
  parameter int CHAR_SIZE     = 16,
  parameter int MONSTER_SIZE  = 16,
  parameter int BULLET_SIZE   = 4,
  parameter int INVULN_FRAMES = 60
) (
  input logic                  Clk,
  input logic                  Reset,
  player_hit_detector_if.slave bus
);
  localparam logic [10:0] CS = 11'(CHAR_SIZE);
  localparam logic [10:0] MS = 11'(MONSTER_SIZE);
  localparam logic [10:0] BS = 11'(BULLET_SIZE);
  localparam logic [7:0]  IF_N = 8'(INVULN_FRAMES);

  typedef enum logic [1:0] {ARMED, CHECK, HIT, INVULN} state_t;

  state_t state;
  logic [7:0] inv_cnt;
  logic       frame_q;
  logic       fe;

  // Snapshot of every box, taken on the frame edge so the check sees one frame.
  logic [9:0]       cx_s, cy_s;
  logic [1:0][9:0]  mx_s, my_s;
  logic [3:0][9:0]  bx_s, by_s;

  logic [1:0][9:0]  mx_in, my_in;
  logic [3:0][9:0]  bx_in, by_in;
  logic [1:0]       mon_hit;
  logic [3:0]       blt_hit;

  assign mx_in = {bus.Monster_X_2, bus.Monster_X};
  assign my_in = {bus.Monster_Y_2, bus.Monster_Y};
  assign bx_in = {bus.monster_bullet_X_D, bus.monster_bullet_X_U,
                  bus.monster_bullet_X_R, bus.monster_bullet_X_L};
  assign by_in = {bus.monster_bullet_Y_D, bus.monster_bullet_Y_U,
                  bus.monster_bullet_Y_R, bus.monster_bullet_Y_L};

  assign fe = bus.frame_clk & ~frame_q;

  // Box overlap at 11 bits so far-edge sums near 1023 cannot wrap.
  // A box parked at (0,0) is an absent object and never overlaps.
  function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay, input logic [10:0] a,
                                   input logic [9:0] bx, input logic [9:0] by, input logic [10:0] b);
    logic [10:0] ax_e, ay_e, bx_e, by_e;
    logic present;
    ax_e = {1'b0, ax} + a - 11'd1;
    ay_e = {1'b0, ay} + a - 11'd1;
    bx_e = {1'b0, bx} + b - 11'd1;
    by_e = {1'b0, by} + b - 11'd1;
    present = ((ax != 10'd0) || (ay != 10'd0)) && ((bx != 10'd0) || (by != 10'd0));
    overlap = present && ({1'b0, ax} <= bx_e) && ({1'b0, bx} <= ax_e) &&
              ({1'b0, ay} <= by_e) && ({1'b0, by} <= ay_e);
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_mon
    assign mon_hit[i] = overlap(cx_s, cy_s, CS, mx_s[i], my_s[i], MS);
  end
  for (genvar i = 0; i < 4; i++) begin : g_blt
    assign blt_hit[i] = overlap(cx_s, cy_s, CS, bx_s[i], by_s[i], BS);
  end

  // Frame-driven FSM with registered outputs; disable acts as reset.
  always_ff @(posedge Clk) begin
    if (Reset || !bus.enable) begin
      state            <= ARMED;
      inv_cnt          <= 8'd0;
      frame_q          <= 1'b0;
      cx_s             <= '0;
      cy_s             <= '0;
      mx_s             <= '0;
      my_s             <= '0;
      bx_s             <= '0;
      by_s             <= '0;
      bus.hited        <= 1'b0;
      bus.bullet_clear <= 4'd0;
      bus.invuln       <= 1'b0;
    end else begin
      frame_q <= bus.frame_clk;
      case (state)
        ARMED: if (fe) begin
          cx_s  <= bus.Char_X;
          cy_s  <= bus.Char_Y;
          mx_s  <= mx_in;
          my_s  <= my_in;
          bx_s  <= bx_in;
          by_s  <= by_in;
          state <= CHECK;
        end
        CHECK: begin
          if ((|mon_hit) || (|blt_hit)) begin
            bus.hited        <= 1'b1;
            bus.bullet_clear <= blt_hit;
            state            <= HIT;
          end else begin
            state <= ARMED;
          end
        end
        HIT: begin
          bus.hited        <= 1'b0;
          bus.bullet_clear <= 4'd0;
          bus.invuln       <= 1'b1;
          inv_cnt          <= IF_N;
          state            <= INVULN;
        end
        INVULN: if (fe) begin
          inv_cnt <= inv_cnt - 8'd1;
          if (inv_cnt == 8'd1) begin
            bus.invuln <= 1'b0;
            state      <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end
endmodule

// File: tb/tb_player_hit_detector.sv
// Directed bench for player_hit_detector with a 3-frame immunity window.
module tb_player_hit_detector;
  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;

  player_hit_detector_if bus();

  player_hit_detector #(
    .CHAR_SIZE(16), .MONSTER_SIZE(16), .BULLET_SIZE(4), .INVULN_FRAMES(3)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_objs();
    bus.Char_X = 0; bus.Char_Y = 0;
    bus.Monster_X = 0; bus.Monster_Y = 0; bus.Monster_X_2 = 0; bus.Monster_Y_2 = 0;
    bus.monster_bullet_X_L = 0; bus.monster_bullet_Y_L = 0;
    bus.monster_bullet_X_R = 0; bus.monster_bullet_Y_R = 0;
    bus.monster_bullet_X_U = 0; bus.monster_bullet_Y_U = 0;
    bus.monster_bullet_X_D = 0; bus.monster_bullet_Y_D = 0;
  endtask

  // Raise the tick for one cycle; returns in the cycle after the edge.
  task automatic do_fe();
    bus.frame_clk = 1'b1;
    step();
    bus.frame_clk = 1'b0;
  endtask

  // Called right after do_fe: expects hited exactly at k+2 then immunity.
  task automatic hit_seq(input string tag, input logic [3:0] mask);
    chk({tag, "_k1_hited"}, 32'(bus.hited), 32'd0);
    step();
    chk({tag, "_k2_hited"}, 32'(bus.hited), 32'd1);
    chk({tag, "_k2_clear"}, 32'(bus.bullet_clear), 32'(mask));
    step();
    chk({tag, "_k3_hited"}, 32'(bus.hited), 32'd0);
    chk({tag, "_k3_invuln"}, 32'(bus.invuln), 32'd1);
  endtask

  task automatic nohit_seq(input string tag);
    step();
    step();
    chk({tag, "_hited"}, 32'(bus.hited), 32'd0);
    step();
    chk({tag, "_invuln"}, 32'(bus.invuln), 32'd0);
  endtask

  task automatic drop_enable();
    bus.enable = 1'b0;
    step();
    bus.enable = 1'b1;
    step();
  endtask

  initial begin
    Reset = 1'b1;
    bus.enable = 1'b1;
    bus.frame_clk = 1'b0;
    clear_objs();
    step();
    step();
    chk("rst_hited", 32'(bus.hited), 32'd0);
    chk("rst_clear", 32'(bus.bullet_clear), 32'd0);
    chk("rst_invuln", 32'(bus.invuln), 32'd0);
    Reset = 1'b0;
    step();

    // Bullet L overlapping the player.
    bus.Char_X = 98; bus.Char_Y = 98;
    bus.monster_bullet_X_L = 100; bus.monster_bullet_Y_L = 100;
    do_fe();
    hit_seq("bulletL", 4'b0001);
    drop_enable();
    chk("bulletL_exit_invuln", 32'(bus.invuln), 32'd0);

    // Edge touch: bullet R at 216 is outside, at 215 it touches.
    clear_objs();
    bus.Char_X = 200; bus.Char_Y = 200;
    bus.monster_bullet_X_R = 216; bus.monster_bullet_Y_R = 200;
    do_fe();
    nohit_seq("edge216");
    bus.monster_bullet_X_R = 215;
    do_fe();
    hit_seq("edge215", 4'b0010);
    drop_enable();

    // Monster overlap held for six frames with a 3-frame window.
    clear_objs();
    bus.Char_X = 200; bus.Char_Y = 200;
    bus.Monster_X = 205; bus.Monster_Y = 190;
    do_fe();
    hit_seq("fe1", 4'b0000);
    do_fe();
    chk("fe2_invuln", 32'(bus.invuln), 32'd1);
    step(); step();
    chk("fe2_hited", 32'(bus.hited), 32'd0);
    do_fe();
    chk("fe3_invuln", 32'(bus.invuln), 32'd1);
    step(); step();
    chk("fe3_hited", 32'(bus.hited), 32'd0);
    do_fe();
    chk("fe4_invuln", 32'(bus.invuln), 32'd0);
    step();
    do_fe();
    hit_seq("fe5", 4'b0000);
    do_fe();
    step(); step();
    chk("fe6_hited", 32'(bus.hited), 32'd0);
    chk("fe6_invuln", 32'(bus.invuln), 32'd1);
    drop_enable();

    // Near the 1023 corner: sums exceed 10 bits.
    clear_objs();
    bus.Char_X = 1015; bus.Char_Y = 1015;
    bus.Monster_X_2 = 1020; bus.Monster_Y_2 = 1020;
    do_fe();
    hit_seq("corner", 4'b0000);
    drop_enable();

    // Every object parked at the origin.
    clear_objs();
    do_fe();
    nohit_seq("absent");

    // Several bullets at once: one pulse, combined mask.
    clear_objs();
    bus.Char_X = 300; bus.Char_Y = 300;
    bus.monster_bullet_X_U = 310; bus.monster_bullet_Y_U = 297;
    bus.monster_bullet_X_D = 302; bus.monster_bullet_Y_D = 312;
    bus.monster_bullet_X_L = 330; bus.monster_bullet_Y_L = 300;
    do_fe();
    hit_seq("multi", 4'b1100);
    drop_enable();

    // Enable dropped while in CHECK with an overlap present.
    clear_objs();
    bus.Char_X = 98; bus.Char_Y = 98;
    bus.monster_bullet_X_L = 100; bus.monster_bullet_Y_L = 100;
    do_fe();
    bus.enable = 1'b0;
    step();
    chk("drop_hited", 32'(bus.hited), 32'd0);
    chk("drop_invuln", 32'(bus.invuln), 32'd0);
    chk("drop_clear", 32'(bus.bullet_clear), 32'd0);
    bus.enable = 1'b1;
    step(); step();
    chk("drop_after_hited", 32'(bus.hited), 32'd0);
    chk("drop_after_invuln", 32'(bus.invuln), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
